// File: rtl/branch_target_unit.sv
// Branch target unit: LUT-based branch targets, zero flag and return-address stack feeding the PC.
// Branch outputs are combinational, state updates on posedge; define BTU_ZFWD_EN to forward ZeroIn to BZ/BZR.
module branch_target_unit #(
  parameter int L         = 10,
  parameter int LUT_W     = 4,
  parameter int RAS_DEPTH = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [LUT_W-1:0] LutIdx,
  input  logic [L-1:0]     PcIn,
  input  logic             FlagWe,
  input  logic             ZeroIn,
  input  logic             LutWe,
  input  logic [LUT_W-1:0] LutWaddr,
  input  logic [L-1:0]     LutWdata,
  output logic [L-1:0]     Target,
  output logic             BaddEn,
  output logic             BsubEn,
  output logic             Zero,
  output logic             RasFull,
  output logic             RasEmpty,
  output logic             Fault
);

  localparam int PTR_W = $clog2(RAS_DEPTH + 1);
  localparam int IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [PTR_W-1:0] FULL_PTR = PTR_W'(RAS_DEPTH);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_BZ   = 3'b001;
  localparam logic [2:0] OP_BZR  = 3'b010;
  localparam logic [2:0] OP_JMP  = 3'b011;
  localparam logic [2:0] OP_CALL = 3'b100;
  localparam logic [2:0] OP_RET  = 3'b101;

  logic [L-1:0]     lut_q [2**LUT_W];
  logic [L-1:0]     ras_q [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr_q, ras_ptr_d;
  logic             zf_q;
  logic             fault_q, fault_d;
  logic             push;
  logic             zf_use;
  logic [PTR_W-1:0] top_ptr;
  logic [IDX_W-1:0] top_idx;
  logic [IDX_W-1:0] push_idx;

  // ptr counts valid entries, so the top entry sits one below it
  assign top_ptr  = ras_ptr_q - PTR_W'(1);
  assign top_idx  = top_ptr[IDX_W-1:0];
  assign push_idx = ras_ptr_q[IDX_W-1:0];
  assign RasFull  = (ras_ptr_q == FULL_PTR);
  assign RasEmpty = (ras_ptr_q == '0);
  assign Fault    = fault_q;

`ifdef BTU_ZFWD_EN
  assign zf_use = FlagWe ? ZeroIn : zf_q;
`else
  assign zf_use = zf_q;
`endif

  always_comb begin
    Target    = '0;
    BaddEn    = 1'b0;
    BsubEn    = 1'b0;
    Zero      = 1'b0;
    push      = 1'b0;
    ras_ptr_d = ras_ptr_q;
    fault_d   = fault_q;
    if (!Reset && !Start) begin
      case (Op)
        OP_NOP: ;
        OP_BZ: begin
          Target = lut_q[LutIdx];
          BaddEn = 1'b1;
          Zero   = zf_use;
        end
        OP_BZR: begin
          Target = lut_q[LutIdx];
          BsubEn = 1'b1;
          Zero   = zf_use;
        end
        OP_JMP: begin
          Target = lut_q[LutIdx];
          BaddEn = 1'b1;
          Zero   = 1'b1;
        end
        OP_CALL: begin
          if (!RasFull) begin
            Target    = lut_q[LutIdx];
            BaddEn    = 1'b1;
            Zero      = 1'b1;
            push      = 1'b1;
            ras_ptr_d = ras_ptr_q + PTR_W'(1);
          end else begin
            fault_d = 1'b1;
          end
        end
        OP_RET: begin
          if (!RasEmpty) begin
            Target    = ras_q[top_idx];
            BaddEn    = 1'b1;
            Zero      = 1'b1;
            ras_ptr_d = top_ptr;
          end else begin
            fault_d = 1'b1;
          end
        end
        default: fault_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 2**LUT_W; i++) lut_q[i] <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
      ras_ptr_q <= '0;
      zf_q      <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      // LUT and flag writes bypass Start so software can preload while the PC is held
      if (LutWe) lut_q[LutWaddr] <= LutWdata;
      if (FlagWe) zf_q <= ZeroIn;
      if (push) ras_q[push_idx] <= PcIn + L'(1);
      ras_ptr_q <= ras_ptr_d;
      fault_q   <= fault_d;
    end
  end

endmodule

// File: tb/tb_branch_target_unit.sv
// Bench for branch_target_unit: directed vectors with literal checks plus a per-cycle reference model.
module tb_branch_target_unit;

  localparam int D = 4;

  logic       Clk;
  logic       Reset;
  logic       Start;
  logic [2:0] Op;
  logic [3:0] LutIdx;
  logic [9:0] PcIn;
  logic       FlagWe;
  logic       ZeroIn;
  logic       LutWe;
  logic [3:0] LutWaddr;
  logic [9:0] LutWdata;
  logic [9:0] Target;
  logic       BaddEn, BsubEn, Zero, RasFull, RasEmpty, Fault;

  int total = 0;
  int bad   = 0;

  logic [9:0] lut_m [16];
  logic [9:0] ras_m [$];
  bit         zf_m, fault_m, started;

  branch_target_unit #(.L(10), .LUT_W(4), .RAS_DEPTH(D)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .LutIdx(LutIdx), .PcIn(PcIn),
    .FlagWe(FlagWe), .ZeroIn(ZeroIn), .LutWe(LutWe), .LutWaddr(LutWaddr), .LutWdata(LutWdata),
    .Target(Target), .BaddEn(BaddEn), .BsubEn(BsubEn), .Zero(Zero),
    .RasFull(RasFull), .RasEmpty(RasEmpty), .Fault(Fault)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: architectural state updated at each posedge from the inputs seen there
  always @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 16; i++) lut_m[i] = '0;
      ras_m.delete();
      zf_m    = 0;
      fault_m = 0;
      started = 1;
    end else if (started) begin
      if (!Start) begin
        if (Op == 3'd4) begin
          if (ras_m.size() < D) ras_m.push_back(PcIn + 10'd1);
          else fault_m = 1;
        end else if (Op == 3'd5) begin
          if (ras_m.size() > 0) void'(ras_m.pop_back());
          else fault_m = 1;
        end else if (Op >= 3'd6) begin
          fault_m = 1;
        end
      end
      if (LutWe) lut_m[LutWaddr] = LutWdata;
      if (FlagWe) zf_m = ZeroIn;
    end
  end

  always @(negedge Clk) begin
    logic [9:0] e_t;
    logic       e_ba, e_bs, e_z;
    if (started) begin
      e_t = '0; e_ba = 0; e_bs = 0; e_z = 0;
      if (!Reset && !Start) begin
        case (Op)
          3'd1: begin e_t = lut_m[LutIdx]; e_ba = 1; e_z = zf_m; end
          3'd2: begin e_t = lut_m[LutIdx]; e_bs = 1; e_z = zf_m; end
          3'd3: begin e_t = lut_m[LutIdx]; e_ba = 1; e_z = 1; end
          3'd4: if (ras_m.size() < D) begin e_t = lut_m[LutIdx]; e_ba = 1; e_z = 1; end
          3'd5: if (ras_m.size() > 0) begin e_t = ras_m[$]; e_ba = 1; e_z = 1; end
          default: ;
        endcase
      end
      chk("mdl_target", 32'(Target), 32'(e_t));
      chk("mdl_baddEn", 32'(BaddEn), 32'(e_ba));
      chk("mdl_bsubEn", 32'(BsubEn), 32'(e_bs));
      chk("mdl_zero", 32'(Zero), 32'(e_z));
      chk("mdl_rasfull", 32'(RasFull), 32'(ras_m.size() == D));
      chk("mdl_rasempty", 32'(RasEmpty), 32'(ras_m.size() == 0));
      chk("mdl_fault", 32'(Fault), 32'(fault_m));
    end
  end

  task automatic setin(input logic [2:0] op, input logic [3:0] idx, input logic [9:0] pc);
    Reset = 0; Start = 0; Op = op; LutIdx = idx; PcIn = pc;
    FlagWe = 0; ZeroIn = 0; LutWe = 0; LutWaddr = '0; LutWdata = '0;
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic lutw(input logic [3:0] a, input logic [9:0] d);
    setin(3'd0, 4'd0, 10'd0);
    LutWe = 1; LutWaddr = a; LutWdata = d;
    tick();
  endtask

  task automatic do_reset;
    setin(3'd3, 4'd3, 10'd0);
    Reset = 1;
    tick();
  endtask

  initial begin
    started = 0;
    setin(3'd3, 4'd3, 10'd0);
    Reset = 1;
    tick();
    #2;
    chk("rst_zero", 32'(Zero), 32'd0);
    chk("rst_baddEn", 32'(BaddEn), 32'd0);
    chk("rst_rasempty", 32'(RasEmpty), 32'd1);
    chk("rst_rasfull", 32'(RasFull), 32'd0);
    chk("rst_fault", 32'(Fault), 32'd0);
    tick();

    // Test 1: LUT write then JMP
    lutw(4'd3, 10'h120);
    lutw(4'd1, 10'h005);
    lutw(4'd2, 10'h2AA);
    setin(3'd3, 4'd3, 10'd0); #2;
    chk("t1_target", 32'(Target), 32'h120);
    chk("t1_baddEn", 32'(BaddEn), 32'd1);
    chk("t1_zero", 32'(Zero), 32'd1);
    tick();

    // Test 2: flag then BZR; same-cycle FlagWe+BZ sees the old flag
    setin(3'd0, 4'd0, 10'd0); FlagWe = 1; ZeroIn = 1; tick();
    setin(3'd2, 4'd1, 10'd0); #2;
    chk("t2_bzr_target", 32'(Target), 32'h5);
    chk("t2_bzr_bsubEn", 32'(BsubEn), 32'd1);
    chk("t2_bzr_baddEn", 32'(BaddEn), 32'd0);
    chk("t2_bzr_zero", 32'(Zero), 32'd1);
    tick();
    setin(3'd1, 4'd1, 10'd0); FlagWe = 1; ZeroIn = 0; #2;
    chk("t2_bz_oldzf", 32'(Zero), 32'd1);
    tick();
    setin(3'd1, 4'd1, 10'd0); #2;
    chk("t2_bz_newzf", 32'(Zero), 32'd0);
    tick();

    // Same-cycle LUT write and read returns the old entry
    setin(3'd3, 4'd2, 10'd0); LutWe = 1; LutWaddr = 4'd2; LutWdata = 10'h111; #2;
    chk("lut_old", 32'(Target), 32'h2AA);
    tick();
    setin(3'd3, 4'd2, 10'd0); #2;
    chk("lut_new", 32'(Target), 32'h111);
    tick();

    // Test 3: CALL then RET
    setin(3'd4, 4'd3, 10'h040); #2;
    chk("t3_call_target", 32'(Target), 32'h120);
    chk("t3_call_zero", 32'(Zero), 32'd1);
    tick();
    setin(3'd5, 4'd0, 10'h120); #2;
    chk("t3_ret_target", 32'(Target), 32'h041);
    chk("t3_ret_baddEn", 32'(BaddEn), 32'd1);
    chk("t3_ret_zero", 32'(Zero), 32'd1);
    tick();
    setin(3'd0, 4'd0, 10'd0); #2;
    chk("t3_rasempty", 32'(RasEmpty), 32'd1);
    chk("t3_fault", 32'(Fault), 32'd0);

    // Test 4: overflow and underflow
    for (int i = 0; i < D; i++) begin
      setin(3'd4, 4'd3, 10'h100 + 10'(i)); tick();
    end
    setin(3'd4, 4'd3, 10'h200); #2;
    chk("t4_full_zero", 32'(Zero), 32'd0);
    chk("t4_full_flag", 32'(RasFull), 32'd1);
    tick();
    chk("t4_full_fault", 32'(Fault), 32'd1);
    for (int i = D; i > 0; i--) begin
      setin(3'd5, 4'd0, 10'd0); #2;
      chk("t4_ret_target", 32'(Target), 32'h100 + 32'(i));
      tick();
    end
    setin(3'd5, 4'd0, 10'd0); #2;
    chk("t4_empty_zero", 32'(Zero), 32'd0);
    tick();
    chk("t4_empty_rasempty", 32'(RasEmpty), 32'd1);
    chk("t4_empty_fault", 32'(Fault), 32'd1);

    // Test 6a: Start holds branch outputs and state, but LUT writes still land
    do_reset();
    lutw(4'd3, 10'h155);
    setin(3'd3, 4'd3, 10'd0); Start = 1; #2;
    chk("t6_start_target", 32'(Target), 32'd0);
    chk("t6_start_zero", 32'(Zero), 32'd0);
    chk("t6_start_baddEn", 32'(BaddEn), 32'd0);
    tick();
    setin(3'd7, 4'd0, 10'd0); Start = 1; LutWe = 1; LutWaddr = 4'd4; LutWdata = 10'h0AB; tick();
    setin(3'd4, 4'd4, 10'd9); Start = 1; tick();
    chk("t6_start_nofault", 32'(Fault), 32'd0);
    chk("t6_start_nopush", 32'(RasEmpty), 32'd1);
    setin(3'd3, 4'd4, 10'd0); #2;
    chk("t6_start_lutw", 32'(Target), 32'h0AB);
    tick();

    // Test 5: PC wrap on CALL, illegal opcode
    setin(3'd4, 4'd0, 10'h3FF); tick();
    setin(3'd5, 4'd0, 10'd0); #2;
    chk("t5_wrap_target", 32'(Target), 32'h000);
    chk("t5_wrap_zero", 32'(Zero), 32'd1);
    tick();
    setin(3'd6, 4'd3, 10'd0); #2;
    chk("t5_ill_target", 32'(Target), 32'd0);
    chk("t5_ill_zero", 32'(Zero), 32'd0);
    chk("t5_ill_prefault", 32'(Fault), 32'd0);
    tick();
    chk("t5_ill_fault", 32'(Fault), 32'd1);

    // Test 6b: Reset mid-stack overrides Op/LutWe/FlagWe
    setin(3'd4, 4'd3, 10'h010); tick();
    setin(3'd4, 4'd3, 10'h020); tick();
    chk("t6_stack_nonempty", 32'(RasEmpty), 32'd0);
    setin(3'd4, 4'd3, 10'h030); Reset = 1; LutWe = 1; LutWaddr = 4'd3; LutWdata = 10'h3FF;
    FlagWe = 1; ZeroIn = 1; #2;
    chk("t6_rst_zero", 32'(Zero), 32'd0);
    tick();
    setin(3'd1, 4'd3, 10'd0); #2;
    chk("t6_rst_rasempty", 32'(RasEmpty), 32'd1);
    chk("t6_rst_fault", 32'(Fault), 32'd0);
    chk("t6_rst_lut", 32'(Target), 32'd0);
    chk("t6_rst_zf", 32'(Zero), 32'd0);
    tick();

    // Mixed traffic checked only by the model
    for (int n = 0; n < 150; n++) begin
      setin(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 10'($urandom_range(0, 1023)));
      Start    = ($urandom_range(0, 7) == 0);
      Reset    = ($urandom_range(0, 40) == 0);
      FlagWe   = $urandom_range(0, 1) == 1;
      ZeroIn   = $urandom_range(0, 1) == 1;
      LutWe    = $urandom_range(0, 2) == 0;
      LutWaddr = 4'($urandom_range(0, 15));
      LutWdata = 10'($urandom_range(0, 1023));
      tick();
    end

    setin(3'd0, 4'd0, 10'd0);
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
